// File: rtl/poly_tone_engine_pkg.sv
// Shared constants for the polyphonic tone engine: wave codes, register
// offsets, CTRL bit positions, FSM states and the noise LFSR definition.
package tone_pkg;

    localparam logic [1:0] WAVE_SQUARE = 2'd0;
    localparam logic [1:0] WAVE_SAW    = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_NOISE  = 2'd3;

    localparam logic [1:0] REG_FREQ = 2'd0;
    localparam logic [1:0] REG_VOL  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    localparam int CTRL_WAVE_LSB = 0;
    localparam int CTRL_WAVE_MSB = 1;
    localparam int CTRL_EN       = 2;
    localparam int CTRL_PRST     = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // One right-shifting Galois step; the polynomial is folded in when bit 0 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/poly_tone_engine_if.sv
// Register write port from the SPI decoder: address, data and a one-cycle strobe.
interface poly_tone_engine_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] addr_in;
    logic [15:0]       data_in;
    logic              data_valid_in;

    modport master (output addr_in, data_in, data_valid_in);
    modport slave  (input  addr_in, data_in, data_valid_in);
endinterface

// File: rtl/tone_wave_shaper.sv
// Combinational waveform generator and volume scaler for one voice.
// Noise (wave code 3) is only produced when TONE_NOISE_EN is defined;
// otherwise that code yields silence.
module tone_wave_shaper
    import tone_pkg::*;
#(
    parameter int PHASE_W  = 16,
    parameter int SAMPLE_W = 16,
    parameter int VOL_W    = 4
) (
    input  logic [PHASE_W-1:0]         phase,
    input  logic [1:0]                 wave,
    input  logic [VOL_W-1:0]           vol,
    input  logic [15:0]                lfsr,
    output logic signed [SAMPLE_W-1:0] sample
);

    localparam logic [SAMPLE_W-1:0] SQ_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SQ_NEG = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

    logic [SAMPLE_W-1:0]         p;
    logic                        m;
    logic [SAMPLE_W-1:0]         p_sh;
    logic [SAMPLE_W-1:0]         fold;
    logic signed [SAMPLE_W-1:0]  wave_s;
    logic signed [SAMPLE_W+VOL_W:0] prod;
    logic                        unused_bits;

    assign p           = phase[PHASE_W-1 -: SAMPLE_W];
    assign m           = p[SAMPLE_W-1];
    assign p_sh        = {p[SAMPLE_W-2:0], 1'b0};
    assign fold        = m ? ~p_sh : p_sh;
    assign unused_bits = ^{lfsr, phase};

`ifdef TONE_NOISE_EN
    logic [SAMPLE_W-1:0] noise;
    generate
        if (SAMPLE_W <= 16) begin : g_noise_slice
            assign noise = lfsr[15 -: SAMPLE_W];
        end else begin : g_noise_ext
            assign noise = {{(SAMPLE_W-16){1'b0}}, lfsr};
        end
    endgenerate
`endif

    // Select the raw bipolar waveform, then scale by the unsigned volume.
    always_comb begin
        wave_s = '0;
        case (wave)
            WAVE_SQUARE: wave_s = m ? SQ_NEG : SQ_POS;
            WAVE_SAW:    wave_s = {~p[SAMPLE_W-1], p[SAMPLE_W-2:0]};
            WAVE_TRI:    wave_s = {~fold[SAMPLE_W-1], fold[SAMPLE_W-2:0]};
`ifdef TONE_NOISE_EN
            WAVE_NOISE:  wave_s = noise;
`else
            WAVE_NOISE:  wave_s = '0;
`endif
            default:     wave_s = '0;
        endcase
        prod   = wave_s * $signed({1'b0, vol});
        sample = SAMPLE_W'(prod >>> VOL_W);
    end

endmodule

// File: rtl/poly_tone_engine.sv
// Time-multiplexed polyphonic oscillator bank. One voice is mixed per clock
// after each sample tick; the saturated sum lands on data_out NUM_VOICES+1
// cycles after the tick. Define TONE_NOISE_EN to give each voice a noise LFSR.
module poly_tone_engine
    import tone_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int SAMPLE_W   = 16,
    parameter int VOL_W      = 4,
    parameter int ADDR_W     = 6
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic                       sample_tick_in,
    poly_tone_engine_if.slave          wr,
    output logic signed [SAMPLE_W-1:0] data_out,
    output logic                       data_valid_out,
    output logic                       overrun_out
);

    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int VSEL_W = ADDR_W - 2;
    localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    state_t state_q, state_nxt;
    logic [VIDX_W-1:0] vidx_q;
    logic signed [ACC_W-1:0] acc_q, acc_nxt;

    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [PHASE_W-1:0] freq_q  [NUM_VOICES];
    logic [VOL_W-1:0]   vol_q   [NUM_VOICES];
    logic [1:0]         wave_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q;

    logic [VSEL_W-1:0]     wr_voice;
    logic [1:0]            wr_off;
    logic                  wr_hit;
    logic [NUM_VOICES-1:0] prst_hit;

    logic                       cur_en;
    logic [PHASE_W-1:0]         cur_phase, new_phase;
    logic [15:0]                shaper_lfsr;
    logic signed [SAMPLE_W-1:0] shaped, contrib, sat_val;
    logic                       mix_last;

    // Address decode; out-of-range voices and the reserved offset never hit.
    always_comb begin
        wr_voice = wr.addr_in[ADDR_W-1:2];
        wr_off   = wr.addr_in[1:0];
        wr_hit   = wr.data_valid_in && (int'(wr_voice) < NUM_VOICES);
        for (int i = 0; i < NUM_VOICES; i++) begin
            prst_hit[i] = wr_hit && (wr_off == REG_CTRL) && (wr_voice == VSEL_W'(i))
                          && wr.data_in[CTRL_PRST];
        end
    end

    // Per-voice configuration registers, writable in any FSM state.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_q[i] <= '0;
                vol_q[i]  <= '0;
                wave_q[i] <= '0;
            end
            en_q <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (wr_voice == VSEL_W'(i)) begin
                    case (wr_off)
                        REG_FREQ: freq_q[i] <= wr.data_in[PHASE_W-1:0];
                        REG_VOL:  vol_q[i]  <= wr.data_in[VOL_W-1:0];
                        REG_CTRL: begin
                            wave_q[i] <= wr.data_in[CTRL_WAVE_MSB:CTRL_WAVE_LSB];
                            en_q[i]   <= wr.data_in[CTRL_EN];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef TONE_NOISE_EN
    logic [15:0] lfsr_q [NUM_VOICES];
    logic [15:0] new_lfsr;

    assign new_lfsr    = cur_en ? lfsr_step(lfsr_q[vidx_q]) : lfsr_q[vidx_q];
    assign shaper_lfsr = new_lfsr;

    // Noise state advances with each enabled mix; a phase-reset strobe reseeds it.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_VOICES; i++) lfsr_q[i] <= LFSR_SEED;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (prst_hit[i])
                    lfsr_q[i] <= LFSR_SEED;
                else if (state_q == ST_MIX && vidx_q == VIDX_W'(i))
                    lfsr_q[i] <= new_lfsr;
            end
        end
    end
`else
    assign shaper_lfsr = 16'h0000;
`endif

    // Datapath for the voice currently being mixed; register reads give old values on same-cycle writes.
    always_comb begin
        cur_en    = en_q[vidx_q];
        cur_phase = phase_q[vidx_q];
        new_phase = cur_en ? cur_phase + freq_q[vidx_q] : cur_phase;
        contrib   = cur_en ? shaped : '0;
        acc_nxt   = acc_q + {{(ACC_W-SAMPLE_W){contrib[SAMPLE_W-1]}}, contrib};
        if (acc_nxt > SAT_HI)
            sat_val = {1'b0, {(SAMPLE_W-1){1'b1}}};
        else if (acc_nxt < SAT_LO)
            sat_val = {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
            sat_val = acc_nxt[SAMPLE_W-1:0];
        mix_last  = (state_q == ST_MIX) && (vidx_q == LAST_V);
    end

    tone_wave_shaper #(
        .PHASE_W  (PHASE_W),
        .SAMPLE_W (SAMPLE_W),
        .VOL_W    (VOL_W)
    ) u_shaper (
        .phase  (new_phase),
        .wave   (wave_q[vidx_q]),
        .vol    (vol_q[vidx_q]),
        .lfsr   (shaper_lfsr),
        .sample (shaped)
    );

    // Phase accumulators; a reset strobe overrides the mix update for that voice.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (prst_hit[i])
                    phase_q[i] <= '0;
                else if (state_q == ST_MIX && vidx_q == VIDX_W'(i))
                    phase_q[i] <= new_phase;
            end
        end
    end

    // FSM state, voice index and mix accumulator.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= ST_IDLE;
            vidx_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q == ST_IDLE && sample_tick_in) begin
                vidx_q <= '0;
                acc_q  <= '0;
            end else if (state_q == ST_MIX) begin
                vidx_q <= vidx_q + 1'b1;
                acc_q  <= acc_nxt;
            end
        end
    end

    // Next-state logic; ticks arriving while busy are dropped and flagged.
    always_comb begin
        state_nxt   = state_q;
        overrun_out = 1'b0;
        case (state_q)
            ST_IDLE: if (sample_tick_in) state_nxt = ST_MIX;
            ST_MIX: begin
                overrun_out = sample_tick_in;
                if (vidx_q == LAST_V) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                overrun_out = sample_tick_in;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The saturated sum is captured as the last voice is mixed so it is valid during OUT.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= mix_last;
            if (mix_last) data_out <= sat_val;
        end
    end

endmodule

// File: tb/tb_poly_tone_engine.sv
// Directed bench for poly_tone_engine with default parameters.
module tb_poly_tone_engine;

    localparam int LAT = 5;

    logic clk_in = 1'b0;
    logic reset_in = 1'b0;
    logic sample_tick_in = 1'b0;
    logic signed [15:0] data_out;
    logic data_valid_out;
    logic overrun_out;

    poly_tone_engine_if #(.ADDR_W(6)) bus ();

    poly_tone_engine dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .sample_tick_in (sample_tick_in),
        .wr             (bus),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]  wave;
        logic        en;
        logic [15:0] freq;
        logic [3:0]  vol;
        int          exp;
    } vec_t;

    vec_t vecs [9];
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk_in);
        bus.addr_in = a;
        bus.data_in = d;
        bus.data_valid_in = 1'b1;
        @(negedge clk_in);
        bus.data_valid_in = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int val, output int lat);
        int c;
        c = start;
        lat = -1;
        val = 0;
        while (lat < 0 && c < start + 30) begin
            @(negedge clk_in);
            c++;
            if (data_valid_out) begin
                lat = c;
                val = data_out;
            end
        end
    endtask

    task automatic do_sample(input string name, input int exp);
        int val, lat;
        @(negedge clk_in);
        sample_tick_in = 1'b1;
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        wait_valid(1, val, lat);
        check(name, val, exp);
        check({name, "_lat"}, lat, LAT);
    endtask

    // Tick, then write (a,d) during the cycle voice 0 is mixed.
    task automatic tick_with_write(input string name, input logic [5:0] a,
                                   input logic [15:0] d, input int exp);
        int val, lat;
        @(negedge clk_in);
        sample_tick_in = 1'b1;
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        bus.addr_in = a;
        bus.data_in = d;
        bus.data_valid_in = 1'b1;
        @(negedge clk_in);
        bus.data_valid_in = 1'b0;
        wait_valid(2, val, lat);
        check(name, val, exp);
        check({name, "_lat"}, lat, LAT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        vecs[0] = '{2'd0, 1'b1, 16'h4000, 4'd15, 30719};
        vecs[1] = '{2'd1, 1'b1, 16'h4000, 4'd15, -15360};
        vecs[2] = '{2'd2, 1'b1, 16'h4000, 4'd15, 0};
        vecs[3] = '{2'd2, 1'b1, 16'h2000, 4'd15, -15360};
        vecs[4] = '{2'd2, 1'b1, 16'hA000, 4'd8,  8191};
        vecs[5] = '{2'd0, 1'b1, 16'hC000, 4'd1,  -2048};
        vecs[6] = '{2'd1, 1'b1, 16'h1234, 4'd0,  0};
`ifdef TONE_NOISE_EN
        vecs[7] = '{2'd3, 1'b1, 16'h4000, 4'd15, -7095};
`else
        vecs[7] = '{2'd3, 1'b1, 16'h4000, 4'd15, 0};
`endif
        vecs[8] = '{2'd0, 1'b0, 16'h4000, 4'd15, 0};

        bus.addr_in = '0;
        bus.data_in = '0;
        bus.data_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset_dout", data_out, 0);
        check("reset_valid", int'(data_valid_out), 0);
        check("reset_overrun", int'(overrun_out), 0);
        reset_in = 1'b1;

        // Single square voice, quarter-cycle steps.
        wr(6'd0, 16'h4000);
        wr(6'd1, 16'd15);
        wr(6'd2, 16'h0004);
        do_sample("sq_t1", 30719);
        do_sample("sq_t2", -30720);
        do_sample("sq_t3", -30720);
        do_sample("sq_t4", 30719);

        // Table of single-voice waveforms, each from a freshly reset phase.
        for (int i = 0; i < 9; i++) begin
            wr(6'd0, vecs[i].freq);
            wr(6'd1, {12'd0, vecs[i].vol});
            wr(6'd2, {1'b1, 12'd0, vecs[i].en, vecs[i].wave});
            do_sample($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Positive and negative saturation with all four voices.
        for (int v = 0; v < 4; v++) begin
            wr(6'(v*4),     16'h1000);
            wr(6'(v*4 + 1), 16'd15);
            wr(6'(v*4 + 2), 16'h8004);
        end
        do_sample("sat_pos", 32767);
        for (int v = 0; v < 4; v++) begin
            wr(6'(v*4 + 2), 16'h8004);
            wr(6'(v*4),     16'h8000);
        end
        do_sample("sat_neg", -32768);
        wr(6'd6, 16'h0000);
        wr(6'd10, 16'h0000);
        wr(6'd14, 16'h0000);

        // Overrun: second tick two cycles after the first is dropped.
        @(negedge clk_in);
        sample_tick_in = 1'b1;
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        @(negedge clk_in);
        sample_tick_in = 1'b1;
        #1;
        check("overrun_hi", int'(overrun_out), 1);
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        #1;
        check("overrun_lo", int'(overrun_out), 0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk_in);
            if (data_valid_out) pulses++;
        end
        check("overrun_pulses", pulses, 1);

        // Write FREQ of voice 0 while voice 0 is being mixed.
        wr(6'd0, 16'h2000);
        wr(6'd1, 16'd15);
        wr(6'd2, 16'h8005);
        tick_with_write("wmix_old", 6'd0, 16'h0100, -23040);
        do_sample("wmix_new", -22800);

        // Out-of-range voice and reserved offset writes are ignored.
        wr(6'h3F, 16'hFFFF);
        wr(6'h10, 16'hFFFF);
        wr(6'h12, 16'h8007);
        wr(6'h11, 16'h0000);
        do_sample("bad_addr", -22560);

        // Saw with phase wrap, then phase-reset strobe.
        wr(6'd0, 16'hFFFF);
        wr(6'd2, 16'h8005);
        do_sample("saw_wrap1", 30719);
        do_sample("saw_wrap2", 30718);
        wr(6'd2, 16'h8005);
        do_sample("saw_prst", 30719);

        // Phase-reset strobe in the cycle voice 0 is mixed: reset wins.
        wr(6'd0, 16'h2000);
        wr(6'd2, 16'h8005);
        tick_with_write("prst_mix_a", 6'd2, 16'h8005, -23040);
        do_sample("prst_mix_b", -23040);

        // Phase-reset strobe on a disabled voice still clears the phase.
        do_sample("dis_pre", -15360);
        wr(6'd2, 16'h8001);
        wr(6'd2, 16'h0005);
        do_sample("dis_prst", -23040);

        // Reset asserted mid-MIX abandons the sample.
        @(negedge clk_in);
        sample_tick_in = 1'b1;
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;
        #1;
        check("rst_mix_dout", data_out, 0);
        check("rst_mix_valid", int'(data_valid_out), 0);
        repeat (2) @(negedge clk_in);
        reset_in = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk_in);
            if (data_valid_out) pulses++;
        end
        check("rst_mix_pulses", pulses, 0);
        do_sample("post_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/poly_tone_engine.md
Name: poly_tone_engine

Overview:
- Next-generation sound core: a parametrised polyphonic oscillator bank with NUM_VOICES time-multiplexed voices.
- Each voice has a frequency word, a volume and a waveform select. Voices are summed with saturation.
- Sits between the SPI register decoder (addr/data/valid write port) and the I2S transmitter. It replaces the single-voice sample counter.
- A sample is computed on every sample tick derived from the master counter.

Parameters:
- NUM_VOICES, 4, voice count (1..16).
- PHASE_W, 16, phase accumulator / frequency word width (≥ SAMPLE_W).
- SAMPLE_W, 16, signed output sample width.
- VOL_W, 4, unsigned per-voice volume width.
- ADDR_W, 6, register address width (must hold NUM_VOICES*4).

Ports:
- clk_in  input  1  system clock.
- reset_in  input  1  asynchronous, active-low reset.
- sample_tick_in  input  1  one-cycle pulse requesting a new sample.
- addr_in  input  ADDR_W  register address.
- data_in  input  16  register write data.
- data_valid_in  input  1  one-cycle write strobe.
- data_out  output  SAMPLE_W  signed mixed sample, held between updates.
- data_valid_out  output  1  one-cycle pulse when data_out updates.
- overrun_out  output  1  one-cycle pulse when a tick is dropped.

Behaviour:
- Reset (reset_in=0, async): all phases, freq, volume, ctrl cleared; data_out=0, data_valid_out=0, overrun_out=0; FSM=IDLE.
- Register map, addr = voice*4 + off:
  - off0 FREQ[PHASE_W-1:0].
  - off1 VOL[VOL_W-1:0].
  - off2 CTRL: [1:0] wave (0 square, 1 saw, 2 triangle, 3 noise/none), [2] enable, [15] phase-reset strobe (self-clearing, not stored).
  - off3 reserved.
  - Voice index ≥ NUM_VOICES, or off3: write ignored.
- Writes are accepted in any FSM state and take effect the cycle after data_valid_in.
- FSM IDLE -> MIX -> OUT -> IDLE:
  - IDLE: on sample_tick_in, clear accumulator, voice index v=0, go MIX.
  - MIX, one voice per cycle for NUM_VOICES cycles:
    - If enabled: phase[v] += FREQ[v], mod 2^PHASE_W (wrap-around silent).
    - Waveform from the new phase, top SAMPLE_W bits p, msb m:
      - square = m ? -(2^(SAMPLE_W-1)-1) : +(2^(SAMPLE_W-1)-1).
      - saw = p with msb inverted, as signed.
      - triangle = fold of p: m ? ~(p<<1) : (p<<1), msb-inverted to signed.
    - scaled = (wave * VOL) >>> VOL_W (signed multiply, arithmetic shift).
    - Add scaled to accumulator of width SAMPLE_W+clog2(NUM_VOICES)+1.
    - Disabled voice: phase frozen, contributes 0.
  - OUT: saturate accumulator to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], register into data_out, pulse data_valid_out, go IDLE.
- Latency: data_valid_out asserts exactly NUM_VOICES+1 cycles after the sample_tick_in cycle.
- sample_tick_in while in MIX or OUT: tick dropped, overrun_out pulses that cycle, and the sample in progress completes normally.
- Write to FREQ/VOL/CTRL of voice v in the same cycle voice v is mixed: the old value is used for that sample.
- Phase-reset strobe in the same cycle voice v is mixed: reset wins, phase[v]=0 afterward.
- Phase-reset strobe on a disabled voice: phase still cleared.
- Reset mid-MIX: sample abandoned, no data_valid_out.

Optional Feature:
- TONE_NOISE_EN defined:
  - One 16-bit Galois LFSR per voice (poly 0xB400, seed 0xACE1 at reset).
  - The LFSR advances once per mix of an enabled voice.
  - Wave code 3 outputs LFSR[15:16-SAMPLE_W], or LFSR zero-extended when SAMPLE_W>16, as signed, then volume scaling.
  - A phase-reset strobe also reseeds that voice's LFSR.
- Undefined: wave code 3 contributes 0; no LFSR storage.

Decomposition:
- Package tone_pkg holds:
  - wave code constants WAVE_SQUARE/SAW/TRI/NOISE;
  - register offsets REG_FREQ/REG_VOL/REG_CTRL;
  - CTRL bit indices;
  - FSM state enum;
  - LFSR seed and polynomial.
- Sub-module tone_wave_shaper: combinational; inputs phase, wave code, volume, lfsr; output scaled signed sample. The mix datapath instantiates it once.

Test Plan:
- Defaults, voice0 FREQ=0x4000, VOL=15, square, enabled -> ticks 1..4 give data_out 30719, -30720, -30720, 30719; data_valid_out exactly 5 cycles after each tick.
- All 4 voices FREQ=0x1000, VOL=15, square, enabled, first tick -> sum 122876 saturates to data_out=32767. Same setup inverted via phase preset 0x8000 -> -32768.
- Tick pulsed 2 cycles after a prior tick -> overrun_out=1 for one cycle; only one data_valid_out pulse for the pair.
- Write voice0 FREQ=0x0100 in the cycle voice0 is mixed -> that sample uses the old FREQ, the next uses 0x0100. Write to addr 0x3F (voice 15 > NUM_VOICES-1) -> no state change.
- Voice0 saw, VOL=15, FREQ=0xFFFF -> phase wraps 0xFFFF, 0xFFFE, ...; saw outputs (0x7FFF*15)>>>4 = 30719, then 30718. Phase-reset strobe -> next sample from phase 0+FREQ.
- Assert reset_in mid-MIX -> outputs 0 immediately, no valid pulse. With TONE_NOISE_EN, wave 3 first output equals the LFSR step after 0xACE1, scaled.
